// File: rtl/mcs_di_bridge.sv
// Bridges MicroBlaze MCS IO-bus strobes onto a DI register read/write handshake.
// Optional watchdog: define MCS_DI_BRIDGE_TIMEOUT_EN to bound every DI wait.
module mcs_di_bridge #(
    parameter int unsigned DI_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    input  logic                     IO_Read_Strobe,
    input  logic                     IO_Write_Strobe,
    input  logic [31:0]              IO_Address,
    input  logic [3:0]               IO_Byte_Enable,
    input  logic [31:0]              IO_Write_Data,
    output logic [31:0]              IO_Read_Data,
    output logic                     IO_Ready,
    input  logic [15:0]              mcs_term_addr,
    output logic [15:0]              mcs_transfer_status,
    output logic [15:0]              di_term_addr,
    output logic [31:0]              di_reg_addr,
    output logic [31:0]              di_len,
    output logic                     di_read_mode,
    output logic                     di_read_req,
    output logic                     di_read,
    input  logic                     di_read_rdy,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    output logic                     di_write_mode,
    output logic                     di_write,
    input  logic                     di_write_rdy,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    input  logic [15:0]              di_transfer_status,
    output logic                     busy,
    output logic                     timeout_flag
);

    localparam int unsigned DW    = DI_DATA_WIDTH;
    localparam int unsigned HALF  = 16;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        WR_ACK  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_beat;
    logic        r_two_beat;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [DW-1:0] w_wr_beat;
    logic [31:0]   w_rd_next;
    logic          w_unused_addr;

    assign w_unused_addr = ^{IO_Address[31:30], IO_Address[1:0]};

    // Low half goes first; the second beat of a 16-bit transfer carries the upper half.
    assign w_wr_beat = DW'(r_beat ? (r_wdata >> HALF) : r_wdata);
    assign w_rd_next = r_beat ? (r_rdata | (32'(di_reg_datao) << HALF)) : 32'(di_reg_datao);

`ifdef MCS_DI_BRIDGE_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout_flag;
    logic             w_in_wait;
    logic             w_progress;
    logic             w_tmo_hit;

    assign w_in_wait  = (r_state == RD_WAIT) || (r_state == WR_WAIT) || (r_state == WR_ACK);
    assign w_progress = ((r_state == RD_WAIT) && di_read_rdy && !di_read) ||
                        ((r_state == WR_WAIT) && di_write_rdy) ||
                        ((r_state == WR_ACK) && di_write_rdy && !di_write);
    assign w_tmo_hit  = w_in_wait && !w_progress && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = r_timeout_flag;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_state             <= IDLE;
            r_beat              <= 1'b0;
            r_two_beat          <= 1'b0;
            r_wdata             <= '0;
            r_rdata             <= '0;
            IO_Read_Data        <= '0;
            IO_Ready            <= 1'b0;
            mcs_transfer_status <= '0;
            di_term_addr        <= '0;
            di_reg_addr         <= '0;
            di_len              <= '0;
            di_read_mode        <= 1'b0;
            di_read_req         <= 1'b0;
            di_read             <= 1'b0;
            di_write_mode       <= 1'b0;
            di_write            <= 1'b0;
            di_reg_datai        <= '0;
            busy                <= 1'b0;
`ifdef MCS_DI_BRIDGE_TIMEOUT_EN
            r_tmo_cnt           <= '0;
            r_timeout_flag      <= 1'b0;
`endif
        end else begin
            di_read_req <= 1'b0;
            di_read     <= 1'b0;
            di_write    <= 1'b0;
            IO_Ready    <= 1'b0;
`ifdef MCS_DI_BRIDGE_TIMEOUT_EN
            r_tmo_cnt <= w_in_wait ? (r_tmo_cnt + TMO_W'(1)) : '0;
`endif
            case (r_state)
                IDLE: begin
                    // Read wins over a simultaneous write; the write is dropped.
                    if (IO_Read_Strobe || IO_Write_Strobe) begin
                        di_term_addr <= mcs_term_addr;
                        di_reg_addr  <= {4'b0000, IO_Address[29:2]};
                        case (IO_Byte_Enable)
                            4'hF:    di_len <= 32'd4;
                            4'h3:    di_len <= 32'd2;
                            default: di_len <= 32'd1;
                        endcase
                        r_two_beat <= (DW == HALF) && (IO_Byte_Enable == 4'hF);
                        r_beat     <= 1'b0;
                        busy       <= 1'b1;
`ifdef MCS_DI_BRIDGE_TIMEOUT_EN
                        r_timeout_flag <= 1'b0;
`endif
                        if (IO_Read_Strobe) begin
                            di_read_mode <= 1'b1;
                            di_read_req  <= 1'b1;
                            r_state      <= RD_REQ;
                        end else begin
                            r_wdata       <= IO_Write_Data;
                            di_write_mode <= 1'b1;
                            r_state       <= WR_WAIT;
                        end
                    end
                end
                RD_REQ: r_state <= RD_WAIT;
                RD_WAIT: begin
                    // Skip the cycle of our own di_read pulse so one rdy is never taken twice.
                    if (di_read_rdy && !di_read) begin
                        di_read <= 1'b1;
                        if (r_two_beat && !r_beat) begin
                            r_rdata <= w_rd_next;
                            r_beat  <= 1'b1;
                        end else begin
                            di_read_mode        <= 1'b0;
                            IO_Ready            <= 1'b1;
                            IO_Read_Data        <= w_rd_next;
                            mcs_transfer_status <= di_transfer_status;
                            r_state             <= RESP;
                        end
                    end
                end
                WR_WAIT: begin
                    if (di_write_rdy) begin
                        di_write     <= 1'b1;
                        di_reg_datai <= w_wr_beat;
                        r_state      <= WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (di_write_rdy && !di_write) begin
                        if (r_two_beat && !r_beat) begin
                            r_beat  <= 1'b1;
                            r_state <= WR_WAIT;
                        end else begin
                            di_write_mode       <= 1'b0;
                            IO_Ready            <= 1'b1;
                            IO_Read_Data        <= '0;
                            mcs_transfer_status <= di_transfer_status;
                            r_state             <= RESP;
                        end
                    end
                end
                RESP: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
`ifdef MCS_DI_BRIDGE_TIMEOUT_EN
            if (w_tmo_hit) begin
                di_read_mode        <= 1'b0;
                di_write_mode       <= 1'b0;
                r_timeout_flag      <= 1'b1;
                IO_Ready            <= 1'b1;
                IO_Read_Data        <= 32'hDEADBEEF;
                mcs_transfer_status <= 16'hFFFF;
                r_state             <= RESP;
            end
`endif
        end
    end

endmodule

// File: doc/mcs_di_bridge.md
MCS_DI_BRIDGE -- requirements
Module: mcs_di_bridge

Interface
REQ-001 SHALL have parameter DI_DATA_WIDTH, default 32, DI data width; legal values 16 or 32.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in ifclk cycles; legal range 2..65535.
REQ-003 ifclk  in  1  sole clock; all logic on posedge.
REQ-004 resetb  in  1  reset, asynchronous, active-low.
REQ-005 IO_Read_Strobe  in  1  one-cycle MCS read request.
REQ-006 IO_Write_Strobe  in  1  one-cycle MCS write request.
REQ-007 IO_Address  in  32  MCS byte address.
REQ-008 IO_Byte_Enable  in  4  MCS byte lanes.
REQ-009 IO_Write_Data  in  32  MCS write data.
REQ-010 IO_Read_Data  out  32  registered read result.
REQ-011 IO_Ready  out  1  one-cycle completion pulse.
REQ-012 mcs_term_addr  in  16  terminal address from MCS.
REQ-013 mcs_transfer_status  out  16  status of the last completed transfer.
REQ-014 di_term_addr  out  16  latched terminal address.
REQ-015 di_reg_addr  out  32  latched register address.
REQ-016 di_len  out  32  transfer length in bytes.
REQ-017 di_read_mode, di_read_req, di_read  out  1 each  DI read controls.
REQ-018 di_read_rdy  in  1; di_reg_datao  in  DI_DATA_WIDTH  DI read data.
REQ-019 di_write_mode, di_write  out  1 each; di_write_rdy  in  1  DI write controls.
REQ-020 di_reg_datai  out  DI_DATA_WIDTH  DI write data for the current beat.
REQ-021 di_transfer_status  in  16  DI status.
REQ-022 busy  out  1  high while state is not IDLE.
REQ-023 timeout_flag  out  1  set by watchdog expiry; cleared by the next accepted strobe.

Function
REQ-024 On an accepted strobe: latch di_term_addr=mcs_term_addr, di_reg_addr={4'b0,IO_Address[29:2]}, and di_len=4/2/1 for Byte_Enable F/3/1; any other Byte_Enable value gives 1.
REQ-025 Beats: 2 when DI_DATA_WIDTH=16 and di_len=4, otherwise 1; the low half is transferred first.
REQ-026 FSM states: IDLE, RD_REQ, RD_WAIT, WR_WAIT, WR_ACK, RESP.
REQ-027 IDLE, read strobe: go to RD_REQ; di_read_mode=1; di_read_req pulses 1 cycle.
REQ-028 RD_WAIT: when di_read_rdy=1, pulse di_read 1 cycle and capture di_reg_datao into the beat's slot that same cycle.
REQ-029 After the last read beat: clear di_read_mode and go to RESP. For 2-beat reads di_read_mode stays high and RD_WAIT is re-entered.
REQ-030 IDLE, write strobe: latch IO_Write_Data; di_write_mode=1; go to WR_WAIT.
REQ-031 WR_WAIT: when di_write_rdy=1, pulse di_write 1 cycle with the beat data; go to WR_ACK.
REQ-032 WR_ACK: wait at least one cycle, then until di_write_rdy=1; then take the next beat, or clear di_write_mode and go to RESP.
REQ-033 RESP: IO_Ready=1 for exactly 1 cycle; IO_Read_Data and mcs_transfer_status=di_transfer_status are valid that cycle; next state IDLE.
REQ-034 Latency: strobe to IO_Ready is no less than 3 cycles.
REQ-035 Narrow reads: zero-extend the result to 32 bits.
REQ-036 Strobes arriving outside IDLE are ignored; simultaneous read and write strobes in IDLE are serviced as a read and the write is dropped.
REQ-037 di_read and di_write are never high in the same cycle.

Reset
REQ-038 resetb low: state=IDLE; every output register is 0, including IO_Ready, IO_Read_Data, mcs_transfer_status, all di_* controls, latched address/len/data, busy and timeout_flag.
REQ-039 Reset asserted mid-transfer aborts the transfer; no IO_Ready is issued after release.

Configuration
REQ-040 With MCS_DI_BRIDGE_TIMEOUT_EN defined: a counter runs in RD_WAIT, WR_WAIT and WR_ACK; at TIMEOUT_CYCLES it drops both modes, sets timeout_flag, and goes to RESP with IO_Read_Data=32'hDEADBEEF and mcs_transfer_status=16'hFFFF.
REQ-041 Without MCS_DI_BRIDGE_TIMEOUT_EN: no counter is built, waits are unbounded, and timeout_flag is tied 0.

Verification
REQ-042 DI_DATA_WIDTH=32, read, BE=F, addr 0xC0000010, di_read_rdy after 5 cycles, data 0x12345678 -> di_reg_addr=4, di_len=4, one di_read pulse, IO_Ready with IO_Read_Data=0x12345678.
REQ-043 DI_DATA_WIDTH=16, write 0xAABBCCDD, BE=F -> di_write beats 0xCCDD then 0xAABB, then one IO_Ready pulse.
REQ-044 DI_DATA_WIDTH=16, read BE=F, beats 0x5678 then 0x1234 -> IO_Read_Data=0x12345678.
REQ-045 Second strobe while busy, and simultaneous read+write strobes -> exactly one transfer, read only.
REQ-046 TIMEOUT_EN, TIMEOUT_CYCLES=8, di_read_rdy held 0 -> IO_Ready at timeout with 0xDEADBEEF/0xFFFF and timeout_flag=1; a reset pulse mid-wait yields all-zero outputs and no IO_Ready.
